fft_stage_sequencer: RTL and testbench

In-place radix-2 decimation-in-time FFT controller that feeds the combinational complex butterfly and consumes its results. It buffers one N-point frame of packed complex samples in bit-reversed order and runs log2(N) stages of one butterfly per cycle, driving the butterfly's `w`, `inA` and `inB` and writing back its `outA`/`outB`. It then streams the N spectrum bins out in natural order. It sits between the sample source (windowing/ADC capture) and the magnitude/visualizer stage.

---
 rtl/fft_pkg.sv | 47 ++++
 rtl/fft_twiddle_rom.sv | 68 ++++++
 rtl/fft_stage_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared defaults, sequencer state encoding and the bit-reverse
//               helper for the radix-2 DIT FFT stage sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default frame geometry: packed complex words, Q1.15 per half
    localparam int FFT_WIDTH = 32;
    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = $clog2(FFT_N);

    // Width of one Q1.15 half (real or imaginary)
    localparam int Q15_WIDTH = 16;

    // Largest supported transform is 64 points
    localparam int MAX_LOG2N = 6;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } seq_state_t;

    // Reverse the low 'bits' bits of 'value'; higher result bits are zero
    function automatic logic [MAX_LOG2N-1:0] bitrev(
        input logic [MAX_LOG2N-1:0] value,
        input int                   bits
    );
        logic [MAX_LOG2N-1:0] src;
        logic [MAX_LOG2N-1:0] result;
        src    = value;
        result = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < bits) begin
                result = {result[MAX_LOG2N-2:0], src[0]};
                src    = src >> 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_rom
// Description : Combinational twiddle table W[t] = exp(-j*2*pi*t/N) in Q1.15,
//               real half on top. Values come from a 64-point quarter-wave
//               cosine table, so every supported N shares one constant list.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = $clog2(N)
) (
    input  logic [LOG2N-2:0]          idx,
    output logic [2*Q15_WIDTH-1:0]    w
);

    // Distance between consecutive N-point twiddles in the 64-point table
    localparam int SPREAD = MAX_LOG2N - LOG2N;

    // round(32767 * cos(2*pi*q/64)) for q = 0..16
    function automatic logic [Q15_WIDTH-1:0] quarter_cos(input logic [4:0] q);
        logic [Q15_WIDTH-1:0] c;
        case (q)
            5'd0:    c = 16'd32767;
            5'd1:    c = 16'd32609;
            5'd2:    c = 16'd32137;
            5'd3:    c = 16'd31356;
            5'd4:    c = 16'd30273;
            5'd5:    c = 16'd28898;
            5'd6:    c = 16'd27245;
            5'd7:    c = 16'd25329;
            5'd8:    c = 16'd23170;
            5'd9:    c = 16'd20787;
            5'd10:   c = 16'd18204;
            5'd11:   c = 16'd15446;
            5'd12:   c = 16'd12539;
            5'd13:   c = 16'd9512;
            5'd14:   c = 16'd6393;
            5'd15:   c = 16'd3212;
            default: c = 16'd0;
        endcase
        return c;
    endfunction

    logic [MAX_LOG2N-1:0] w_k;
    logic [Q15_WIDTH-1:0] w_re;
    logic [Q15_WIDTH-1:0] w_im;

    // Fold the half-circle index onto the quarter-wave table:
    // first quadrant cos>=0, second quadrant cos<0; -sin is always <= 0
    always_comb begin
        w_k = MAX_LOG2N'(idx) << SPREAD;
        if (w_k <= 6'd16) begin
            w_re = quarter_cos(5'(w_k));
            w_im = '0 - quarter_cos(5'(6'd16 - w_k));
        end else begin
            w_re = '0 - quarter_cos(5'(6'd32 - w_k));
            w_im = '0 - quarter_cos(5'(w_k - 6'd16));
        end
    end

    assign w = {w_re, w_im};

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fft_stage_sequencer
// Description : In-place radix-2 DIT FFT controller. Loads one frame in
//               bit-reversed order, runs LOG2N stages of one external
//               butterfly per cycle, then streams bins out in natural order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int N     = FFT_N,
    parameter int LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] bf_w,
    output logic [WIDTH-1:0] bf_inA,
    output logic [WIDTH-1:0] bf_inB,
    input  logic [WIDTH-1:0] bf_outA,
    input  logic [WIDTH-1:0] bf_outB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int STAGE_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int PAIR_W  = LOG2N - 1;

    localparam logic [LOG2N-1:0]   LAST_IDX      = LOG2N'(N - 1);
    localparam logic [PAIR_W-1:0]  LAST_PAIR     = PAIR_W'(N / 2 - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE    = STAGE_W'(LOG2N - 1);
    localparam logic [STAGE_W-1:0] TW_SHIFT_BASE = STAGE_W'(LOG2N - 1);

    seq_state_t         r_state;
    seq_state_t         w_next_state;

    logic [LOG2N-1:0]   r_load_cnt;
    logic [LOG2N-1:0]   r_drain_idx;
    logic [PAIR_W-1:0]  r_pair;
    logic [STAGE_W-1:0] r_stage;

    // Frame storage: async read, two write ports (a, b); never reset
    logic [WIDTH-1:0]   r_mem [N];

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_compute;
    logic               w_pair_last;
    logic               w_stage_last;
    logic [LOG2N-1:0]   w_load_addr;
    logic [LOG2N-1:0]   w_pair_ext;
    logic [LOG2N-1:0]   w_half;
    logic [LOG2N-1:0]   w_pos;
    logic [LOG2N-1:0]   w_addr_a;
    logic [LOG2N-1:0]   w_addr_b;
    logic [STAGE_W-1:0] w_tw_shift;
    logic [PAIR_W-1:0]  w_tw_idx;
    logic [WIDTH-1:0]   w_tw;

    assign w_in_fire    = (r_state == LOAD)  && in_valid;
    assign w_out_fire   = (r_state == DRAIN) && out_ready;
    assign w_compute    = (r_state == COMPUTE);
    assign w_pair_last  = (r_pair  == LAST_PAIR);
    assign w_stage_last = (r_stage == LAST_STAGE);

    // Sample k lands at bitrev(k) so the DIT stages can run in place
    assign w_load_addr = LOG2N'(bitrev(MAX_LOG2N'(r_load_cnt), LOG2N));

    // Butterfly addressing: a = ((j>>s)<<(s+1)) + (j & (half-1)), b = a + half
    assign w_pair_ext = LOG2N'(r_pair);
    assign w_half     = LOG2N'(1) << r_stage;
    assign w_pos      = w_pair_ext & (w_half - LOG2N'(1));
    assign w_addr_a   = (((w_pair_ext >> r_stage) << 1) << r_stage) | w_pos;
    assign w_addr_b   = w_addr_a + w_half;

    // Twiddle index t = pos << (LOG2N-1-s); pos < half keeps t below N/2
    assign w_tw_shift = TW_SHIFT_BASE - r_stage;
    assign w_tw_idx   = w_pos[PAIR_W-1:0] << w_tw_shift;

    fft_twiddle_rom #(
        .N     (N),
        .LOG2N (LOG2N)
    ) u_twiddle_rom (
        .idx (w_tw_idx),
        .w   (w_tw)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: leave each phase on its final transfer/pair
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_in_fire && (r_load_cnt == LAST_IDX))   w_next_state = COMPUTE;
            COMPUTE: if (w_pair_last && w_stage_last)             w_next_state = DRAIN;
            DRAIN:   if (w_out_fire && (r_drain_idx == LAST_IDX)) w_next_state = LOAD;
            default: w_next_state = LOAD;
        endcase
    end

    // Load, stage/pair and drain counters; each wraps to 0 as its phase ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_cnt  <= '0;
            r_drain_idx <= '0;
            r_pair      <= '0;
            r_stage     <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    r_pair <= r_pair + 1'b1;
                    if (w_pair_last) begin
                        r_stage <= w_stage_last ? '0 : r_stage + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        r_drain_idx <= r_drain_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample store during LOAD, butterfly write-back during COMPUTE
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_in_fire) begin
                r_mem[w_load_addr] <= in_data;
            end
            if (w_compute) begin
                r_mem[w_addr_a] <= bf_outA;
                r_mem[w_addr_b] <= bf_outB;
            end
        end
    end

    // Output decode: butterfly operands only in COMPUTE, bins only in DRAIN
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        bf_w      = '0;
        bf_inA    = '0;
        bf_inB    = '0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
            end
            COMPUTE: begin
                busy   = 1'b1;
                bf_w   = w_tw;
                bf_inA = r_mem[w_addr_a];
                bf_inB = r_mem[w_addr_b];
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_mem[r_drain_idx];
                out_last  = (r_drain_idx == LAST_IDX);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_sequencer
// Description : Bench for the FFT stage sequencer with a Q1.15 golden
//               butterfly; expected bins come from a direct floating-point DFT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    localparam int  NN = FFT_N;
    localparam real PI = 3.14159265358979323846;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tol;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] bf_w;
    logic [31:0] bf_inA;
    logic [31:0] bf_inB;
    logic [31:0] bf_outA;
    logic [31:0] bf_outB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    exp_t        sb[$];
    logic [31:0] frame [NN];
    int          n_checks = 0;
    int          n_errs   = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer #(
        .WIDTH (FFT_WIDTH),
        .N     (FFT_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bf_w      (bf_w),
        .bf_inA    (bf_inA),
        .bf_inB    (bf_inB),
        .bf_outA   (bf_outA),
        .bf_outB   (bf_outB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Golden Q1.15 butterfly: A' = A + W*B, B' = A - W*B, product rounded
    function automatic logic [63:0] golden_bfly(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] w);
        logic signed [15:0] ar, ai, br, bi, wr, wi, tr, ti;
        logic signed [31:0] pr, pim;
        ar = a[31:16]; ai = a[15:0];
        br = b[31:16]; bi = b[15:0];
        wr = w[31:16]; wi = w[15:0];
        pr  = wr * br - wi * bi;
        pim = wr * bi + wi * br;
        tr  = 16'((pr  + 32'sd16384) >>> 15);
        ti  = 16'((pim + 32'sd16384) >>> 15);
        return {16'(ar + tr), 16'(ai + ti), 16'(ar - tr), 16'(ai - ti)};
    endfunction

    always_comb begin
        logic [63:0] r;
        r       = golden_bfly(bf_inA, bf_inB, bf_w);
        bf_outA = r[63:32];
        bf_outB = r[31:0];
    end

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic logic [31:0] tw_exp(input int t);
        real ang;
        ang = 2.0 * PI * $itor(t) / $itor(NN);
        return {16'(rnd(32767.0 * $cos(ang))), 16'(rnd(-32767.0 * $sin(ang)))};
    endfunction

    // One comparison: each signed half must lie within tol of the reference
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp, input int tol);
        logic signed [15:0] orr, oi, er, ei;
        int dr, di;
        orr = obs[31:16]; oi = obs[15:0];
        er  = exp[31:16]; ei = exp[15:0];
        dr  = int'(orr) - int'(er);
        di  = int'(oi)  - int'(ei);
        if (dr < 0) dr = -dr;
        if (di < 0) di = -di;
        n_checks++;
        if (dr > tol || di > tol) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Expected spectrum of 'frame' by direct DFT, queued bin by bin
    task automatic push_expected(input int tol);
        logic signed [15:0] xr16, xi16;
        real re, im, ang, xr, xi;
        exp_t e;
        for (int k = 0; k < NN; k++) begin
            re = 0.0;
            im = 0.0;
            for (int n = 0; n < NN; n++) begin
                xr16 = frame[n][31:16];
                xi16 = frame[n][15:0];
                xr   = $itor(xr16);
                xi   = $itor(xi16);
                ang  = -2.0 * PI * $itor(k * n) / $itor(NN);
                re   = re + xr * $cos(ang) - xi * $sin(ang);
                im   = im + xr * $sin(ang) + xi * $cos(ang);
            end
            e.data = {16'(rnd(re)), 16'(rnd(im))};
            e.tol  = 8'(tol);
            sb.push_back(e);
        end
    endtask

    // 0 impulse, 1 DC, 2 tone (x[1] only), 3 distinct ramp
    task automatic set_frame(input int kind, input int tol);
        for (int k = 0; k < NN; k++) begin
            case (kind)
                0:       frame[k] = (k == 0) ? 32'h4000_0000 : 32'h0;
                1:       frame[k] = 32'h0400_0000;
                2:       frame[k] = (k == 1) ? 32'h4000_0000 : 32'h0;
                default: frame[k] = {16'(64 * (k + 1)), 16'(32 * (8 - k))};
            endcase
        end
        push_expected(tol);
    endtask

    // Entered and left at a falling edge; leaves at the first cycle after
    // the last accepted sample
    task automatic load_frame(input bit gaps, input bit hold_valid);
        int k;
        int cyc;
        bit acc;
        k   = 0;
        cyc = 0;
        while (k < NN && cyc < 200) begin
            in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            in_data  = frame[k];
            acc      = in_valid && in_ready;
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
            cyc++;
        end
        if (k < NN) check_val("load_timeout", 32'(k), 32'(NN), 0);
        in_valid = hold_valid;
        in_data  = 32'hDEAD_BEEF;
    endtask

    // Walks COMPUTE one cycle at a time; abort_at >= 0 pulses reset there
    task automatic run_compute(input bit check_addr, input int abort_at);
        int c;
        int s, j, half, pos, t;
        c = 0;
        check_val("compute_start_busy", {31'b0, busy}, 32'd1, 0);
        check_val("compute_in_ready",   {31'b0, in_ready}, 32'd0, 0);
        while (busy && !out_valid && c < 100) begin
            s    = c / (NN / 2);
            j    = c % (NN / 2);
            half = 1 << s;
            pos  = j & (half - 1);
            t    = pos << (FFT_LOG2N - 1 - s);
            check_val($sformatf("bf_w_c%0d", c), bf_w, tw_exp(t), 0);
            if (check_addr && c == 0) begin
                check_val("c0_inA_addr0", bf_inA, frame[0], 0);
                check_val("c0_inB_addr1", bf_inB, frame[8], 0);
            end
            if (check_addr && c == 4) begin
                check_val("c4_inA_addr8_x1", bf_inA, frame[1], 0);
                check_val("c4_inB_addr9_x9", bf_inB, frame[9], 0);
            end
            if (c == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_val("abort_busy",      {31'b0, busy},      32'd0, 0);
                check_val("abort_out_valid", {31'b0, out_valid}, 32'd0, 0);
                check_val("abort_in_ready",  {31'b0, in_ready},  32'd1, 0);
                check_val("abort_bf_w",      bf_w,               32'd0, 0);
                reset = 1'b0;
                sb.delete();
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            c++;
        end
        check_val("compute_len", 32'(c), 32'(FFT_LOG2N * NN / 2), 0);
        check_val("drain_first_valid", {31'b0, out_valid}, 32'd1, 0);
        in_valid = 1'b0;
    endtask

    // Accept all bins, optionally withholding out_ready 3 cycles at stall_bin
    task automatic drain(input int stall_bin);
        int n, cyc, stall;
        logic [31:0] held;
        exp_t e;
        n     = 0;
        cyc   = 0;
        stall = 0;
        held  = '0;
        while (n < NN && cyc < 200) begin
            if (!out_valid) begin
                out_ready = 1'b1;
                check_val("out_valid_high", {31'b0, out_valid}, 32'd1, 0);
            end else if (n == stall_bin && stall < 3) begin
                out_ready = 1'b0;
                if (stall == 0) held = out_data;
                else check_val("stall_hold", out_data, held, 0);
                check_val("stall_last", {31'b0, out_last}, {31'b0, (n == NN - 1)}, 0);
                stall++;
            end else begin
                out_ready = 1'b1;
                if (stall > 0 && n == stall_bin)
                    check_val("stall_release", out_data, held, 0);
                if (sb.size() == 0) begin
                    check_val("sb_empty", 32'd1, 32'd0, 0);
                end else begin
                    e = sb.pop_front();
                    check_val($sformatf("bin%0d", n), out_data, e.data, int'(e.tol));
                end
                check_val($sformatf("last%0d", n), {31'b0, out_last}, {31'b0, (n == NN - 1)}, 0);
                n++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check_val("drain_count",    32'(n), 32'(NN), 0);
        check_val("post_in_ready",  {31'b0, in_ready},  32'd1, 0);
        check_val("post_out_valid", {31'b0, out_valid}, 32'd0, 0);
        check_val("post_busy",      {31'b0, busy},      32'd0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready",  {31'b0, in_ready},  32'd1, 0);
        check_val("rst_busy",      {31'b0, busy},      32'd0, 0);
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0, 0);
        check_val("rst_out_last",  {31'b0, out_last},  32'd0, 0);
        check_val("rst_bf_w",      bf_w,   32'd0, 0);
        check_val("rst_bf_inA",    bf_inA, 32'd0, 0);
        check_val("rst_bf_inB",    bf_inB, 32'd0, 0);

        // Impulse
        set_frame(0, 1);
        load_frame(1'b0, 1'b0);
        run_compute(1'b0, -1);
        drain(-1);

        // DC with backpressure at bin 5
        set_frame(1, 2);
        load_frame(1'b0, 1'b0);
        run_compute(1'b0, -1);
        drain(5);

        // Ramp with input gaps; in_valid left high through COMPUTE
        set_frame(3, 4);
        load_frame(1'b1, 1'b1);
        run_compute(1'b1, -1);
        drain(-1);

        // Single tone
        set_frame(2, 3);
        load_frame(1'b0, 1'b0);
        run_compute(1'b0, -1);
        drain(-1);

        // Abort at COMPUTE cycle 10, then a clean impulse frame
        set_frame(1, 2);
        load_frame(1'b0, 1'b0);
        run_compute(1'b0, 10);
        check_val("abort_sb_cleared", 32'(sb.size()), 32'd0, 0);
        set_frame(0, 1);
        load_frame(1'b0, 1'b0);
        run_compute(1'b0, -1);
        drain(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
